ahb_picomem_bridge: RTL and testbench

AHB-Lite slave that accepts bus transfers and replays each one as a single PicoRV32-native memory request (mem_valid/mem_ready handshake with byte write strobes), so native-interface memories and peripherals can sit behind the AHB fabric. The picorv32_freeahb_adapter maps native requests onto the bus; this block does the reverse. One transfer is outstanding at a time. The block inserts wait states until the native side answers, and it returns an AHB ERROR response on an illegal size, a misaligned address, or a native-side timeout.

---
 rtl/ahb_picomem_bridge_if.sv | 37 +++
 rtl/ahb_picomem_bridge.sv | 146 ++++++++++++++
 tb/tb_ahb_picomem_bridge.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_picomem_bridge_if.sv
// rtl/ahb_picomem_bridge_if.sv - AHB-Lite slave and PicoRV32 native memory signal bundle
interface ahb_picomem_bridge_if;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [3:0]  hprot;
   logic [31:0] hwdata;
   logic        hready;
   logic        hreadyout;
   logic        hresp;
   logic [31:0] hrdata;
   logic        mem_valid;
   logic        mem_instr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   // Bridge view: AHB slave on one side, native requester on the other.
   modport slave (
      input  hsel, haddr, htrans, hwrite, hsize, hprot, hwdata, hready,
      output hreadyout, hresp, hrdata,
      output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata
   );

   // Environment view: AHB master plus native memory.
   modport master (
      output hsel, haddr, htrans, hwrite, hsize, hprot, hwdata, hready,
      input  hreadyout, hresp, hrdata,
      input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/ahb_picomem_bridge.sv
// rtl/ahb_picomem_bridge.sv - AHB-Lite slave replaying each transfer as one PicoRV32 native request
module ahb_picomem_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                     clk,
   input  logic                     resetn,
   ahb_picomem_bridge_if.slave      bus
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WCAP   = 3'd1;
   localparam logic [2:0] S_ACCESS = 3'd2;
   localparam logic [2:0] S_ERR1   = 3'd3;
   localparam logic [2:0] S_ERR2   = 3'd4;

   localparam logic [16:0] TO_LIMIT = 17'(TIMEOUT_CYCLES);

   logic [2:0]  state;
   logic [15:0] timeout_cnt;
   logic        is_write;

   logic        accept;
   logic        legal;
   logic [3:0]  strb;
   logic [16:0] cnt_inc;
   logic        timed_out;
   logic        unused_bits;

   // Attribute bits the native interface has no use for.
   assign unused_bits = ^{bus.hprot[3:1], bus.htrans[0]};

   // Address-phase decode: acceptance, legality and byte-lane strobes.
   always_comb begin
      accept = bus.hsel && bus.hready && bus.htrans[1] &&
               ((state == S_IDLE) || (state == S_ERR2));
      legal  = 1'b0;
      strb   = 4'b1111;
      case (bus.hsize)
         3'b000: begin
            legal = 1'b1;
            strb  = 4'b0001 << bus.haddr[1:0];
         end
         3'b001: begin
            legal = !bus.haddr[0];
            strb  = 4'b0011 << {bus.haddr[1], 1'b0};
         end
         3'b010: begin
            legal = (bus.haddr[1:0] == 2'b00);
            strb  = 4'b1111;
         end
         default: begin
            legal = 1'b0;
            strb  = 4'b1111;
         end
      endcase
   end

   // Timeout fires on the cycle the counter would reach the limit; a zero limit never fires.
   always_comb begin
      cnt_inc   = {1'b0, timeout_cnt} + 17'd1;
      timed_out = (TO_LIMIT != 17'd0) && (cnt_inc == TO_LIMIT);
   end

   // Transfer sequencing, native request registers and AHB response registers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state         <= S_IDLE;
         timeout_cnt   <= 16'd0;
         is_write      <= 1'b0;
         bus.hreadyout <= 1'b1;
         bus.hresp     <= 1'b0;
         bus.hrdata    <= 32'd0;
         bus.mem_valid <= 1'b0;
         bus.mem_instr <= 1'b0;
         bus.mem_addr  <= 32'd0;
         bus.mem_wdata <= 32'd0;
         bus.mem_wstrb <= 4'd0;
      end else begin
         case (state)
            S_IDLE, S_ERR2: begin
               if (accept) begin
                  timeout_cnt <= 16'd0;
                  if (!legal) begin
                     bus.hresp     <= 1'b1;
                     bus.hreadyout <= 1'b0;
                     state         <= S_ERR1;
                  end else begin
                     bus.hresp     <= 1'b0;
                     bus.hreadyout <= 1'b0;
                     bus.mem_addr  <= {bus.haddr[31:2], 2'b00};
                     bus.mem_instr <= ~bus.hprot[0];
                     is_write      <= bus.hwrite;
                     if (bus.hwrite) begin
                        bus.mem_wstrb <= strb;
                        state         <= S_WCAP;
                     end else begin
                        bus.mem_wstrb <= 4'd0;
                        bus.mem_valid <= 1'b1;
                        state         <= S_ACCESS;
                     end
                  end
               end else begin
                  bus.hresp     <= 1'b0;
                  bus.hreadyout <= 1'b1;
                  state         <= S_IDLE;
               end
            end
            S_WCAP: begin
               // Write data only exists in the data phase, one cycle after acceptance.
               bus.mem_wdata <= bus.hwdata;
               bus.mem_valid <= 1'b1;
               state         <= S_ACCESS;
            end
            S_ACCESS: begin
               if (bus.mem_ready) begin
                  bus.mem_valid <= 1'b0;
                  bus.mem_wstrb <= 4'd0;
                  if (!is_write) begin
                     bus.hrdata <= bus.mem_rdata;
                  end
                  bus.hreadyout <= 1'b1;
                  state         <= S_IDLE;
               end else begin
                  timeout_cnt <= cnt_inc[15:0];
                  if (timed_out) begin
                     bus.mem_valid <= 1'b0;
                     bus.hresp     <= 1'b1;
                     bus.hreadyout <= 1'b0;
                     state         <= S_ERR1;
                  end
               end
            end
            S_ERR1: begin
               bus.hresp     <= 1'b1;
               bus.hreadyout <= 1'b1;
               state         <= S_ERR2;
            end
            default: begin
               bus.mem_valid <= 1'b0;
               bus.hresp     <= 1'b0;
               bus.hreadyout <= 1'b1;
               state         <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ahb_picomem_bridge.sv
// tb/tb_ahb_picomem_bridge.sv - self-checking bench for ahb_picomem_bridge
module tb_ahb_picomem_bridge;
   localparam int TO = 4;

   logic clk;
   logic resetn;
   ahb_picomem_bridge_if bus ();

   ahb_picomem_bridge #(.TIMEOUT_CYCLES(TO)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   assign bus.hready = bus.hreadyout;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  prot;
      int          delay;
      logic [31:0] rdata;
      int          exp_waits;
      logic        exp_err;
      int          exp_vcyc;
      logic [31:0] exp_addr;
      logic [3:0]  exp_strb;
      logic        exp_instr;
      logic [31:0] exp_hrdata;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;

   int          o_waits, o_vcyc, o_pulses;
   logic        o_err1, o_resp, o_stable, o_timeout, o_instr;
   logic [31:0] o_hrdata, o_addr, o_wdata;
   logic [3:0]  o_strb;
   logic [31:0] model_rdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One AHB transfer with a native memory that answers on its (delay+1)-th valid cycle.
   task automatic run_xfer(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] prot,
                           input int delay, input logic [31:0] rdata);
      logic prev_v;
      bit   done;
      o_waits = 0; o_vcyc = 0; o_pulses = 0; o_err1 = 0; o_resp = 0;
      o_stable = 1; o_timeout = 0; o_hrdata = 0;
      o_addr = 0; o_wdata = 0; o_strb = 0; o_instr = 0;
      bus.hsel = 1; bus.htrans = 2'b10; bus.haddr = addr; bus.hwrite = wr;
      bus.hsize = size; bus.hprot = prot;
      step();
      bus.hsel = 0; bus.htrans = 2'b00; bus.hwdata = wdata; bus.haddr = $urandom;
      prev_v = 0;
      done   = 0;
      for (int cyc = 0; cyc < 64 && !done; cyc++) begin
         if (bus.mem_valid) begin
            if (!prev_v) begin
               o_pulses++;
               o_addr = bus.mem_addr; o_strb = bus.mem_wstrb;
               o_wdata = bus.mem_wdata; o_instr = bus.mem_instr;
            end else if (o_addr !== bus.mem_addr || o_strb !== bus.mem_wstrb ||
                         o_wdata !== bus.mem_wdata || o_instr !== bus.mem_instr) begin
               o_stable = 0;
            end
            bus.mem_ready = (o_vcyc == delay);
            bus.mem_rdata = (o_vcyc == delay) ? rdata : $urandom;
            o_vcyc++;
         end else begin
            bus.mem_ready = 1'($urandom);
            bus.mem_rdata = $urandom;
         end
         prev_v = bus.mem_valid;
         if (bus.hreadyout) begin
            o_resp   = bus.hresp;
            o_hrdata = bus.hrdata;
            done     = 1;
         end else begin
            o_waits++;
            if (bus.hresp) o_err1 = 1;
            step();
         end
      end
      if (!done) o_timeout = 1;
   endtask

   task automatic check_xfer(input string tag, input logic wr, input int exp_waits,
                             input logic exp_err, input int exp_vcyc, input logic [31:0] exp_addr,
                             input logic [3:0] exp_strb, input logic exp_instr,
                             input logic [31:0] exp_wdata, input logic [31:0] exp_hrdata);
      chk({tag, " bound"}, 32'(o_timeout), 32'd0);
      chk({tag, " waits"}, o_waits, exp_waits);
      chk({tag, " resp"}, {30'd0, o_err1, o_resp}, {30'd0, exp_err, exp_err});
      chk({tag, " valid_cycles"}, o_vcyc, exp_vcyc);
      chk({tag, " pulses"}, o_pulses, (exp_vcyc > 0) ? 1 : 0);
      if (exp_vcyc > 0) begin
         chk({tag, " mem_addr"}, o_addr, exp_addr);
         chk({tag, " mem_wstrb"}, 32'(o_strb), 32'(exp_strb));
         chk({tag, " mem_instr"}, 32'(o_instr), 32'(exp_instr));
         chk({tag, " stable"}, 32'(o_stable), 32'd1);
         if (wr) chk({tag, " mem_wdata"}, o_wdata, exp_wdata);
      end
      chk({tag, " hrdata"}, o_hrdata, exp_hrdata);
   endtask

   vec_t vecs[11];

   initial begin
      int          pulses, stage;
      logic        prev;
      logic [31:0] w_addr, w_data, r_addr;
      logic [3:0]  w_strb;

      vecs[0]  = '{0, 3'd0 + 3'd2, 32'h0000_1004, 32'h0, 4'b0001, 0, 32'hDEAD_BEEF, 1, 0, 1, 32'h0000_1004, 4'b0000, 0, 32'hDEAD_BEEF};
      vecs[1]  = '{1, 3'd0, 32'h0000_2003, 32'hAA00_0000, 4'b0001, 0, 32'h0, 2, 0, 1, 32'h0000_2000, 4'b1000, 0, 32'hDEAD_BEEF};
      vecs[2]  = '{1, 3'd1, 32'h0000_2002, 32'h5566_0000, 4'b0001, 1, 32'h0, 3, 0, 2, 32'h0000_2000, 4'b1100, 0, 32'hDEAD_BEEF};
      vecs[3]  = '{1, 3'd1, 32'h0000_2001, 32'h1234_5678, 4'b0001, 0, 32'h0, 1, 1, 0, 32'h0, 4'b0000, 0, 32'hDEAD_BEEF};
      vecs[4]  = '{0, 3'd3, 32'h0000_3000, 32'h0, 4'b0001, 0, 32'h1111_1111, 1, 1, 0, 32'h0, 4'b0000, 0, 32'hDEAD_BEEF};
      vecs[5]  = '{0, 3'd2, 32'h0000_3002, 32'h0, 4'b0001, 0, 32'h2222_2222, 1, 1, 0, 32'h0, 4'b0000, 0, 32'hDEAD_BEEF};
      vecs[6]  = '{0, 3'd2, 32'h0000_5000, 32'h0, 4'b0000, 9, 32'h3333_3333, 5, 1, 4, 32'h0000_5000, 4'b0000, 1, 32'hDEAD_BEEF};
      vecs[7]  = '{1, 3'd2, 32'h0000_6008, 32'h0102_0304, 4'b0001, 7, 32'h0, 6, 1, 4, 32'h0000_6008, 4'b1111, 0, 32'hDEAD_BEEF};
      vecs[8]  = '{0, 3'd0, 32'h0000_4001, 32'h0, 4'b0000, 2, 32'h1234_5678, 3, 0, 3, 32'h0000_4000, 4'b0000, 1, 32'h1234_5678};
      vecs[9]  = '{0, 3'd1, 32'h0000_4002, 32'h0, 4'b0001, 3, 32'hCAFE_F00D, 4, 0, 4, 32'h0000_4000, 4'b0000, 0, 32'hCAFE_F00D};
      vecs[10] = '{1, 3'd0, 32'h0000_7002, 32'h0033_0000, 4'b0001, 0, 32'h0, 2, 0, 1, 32'h0000_7000, 4'b0100, 0, 32'hCAFE_F00D};

      bus.hsel = 0; bus.haddr = 0; bus.htrans = 0; bus.hwrite = 0; bus.hsize = 0;
      bus.hprot = 0; bus.hwdata = 0; bus.mem_ready = 0; bus.mem_rdata = 0;
      resetn = 0;
      repeat (3) step();
      chk("reset hreadyout", 32'(bus.hreadyout), 32'd1);
      chk("reset hresp", 32'(bus.hresp), 32'd0);
      chk("reset hrdata", bus.hrdata, 32'd0);
      chk("reset mem_valid", 32'(bus.mem_valid), 32'd0);
      chk("reset mem_instr", 32'(bus.mem_instr), 32'd0);
      chk("reset mem_addr", bus.mem_addr, 32'd0);
      chk("reset mem_wdata", bus.mem_wdata, 32'd0);
      chk("reset mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
      resetn = 1;
      step();

      // IDLE/BUSY transfers and deselected NONSEQ: zero wait states, no request.
      for (int i = 0; i < 6; i++) begin
         bus.hsel   = (i < 4);
         bus.htrans = (i < 4) ? 2'(i % 2) : 2'b10;
         bus.haddr  = 32'h0000_0100;
         step();
         chk($sformatf("idle%0d hreadyout", i), 32'(bus.hreadyout), 32'd1);
         chk($sformatf("idle%0d mem_valid", i), 32'(bus.mem_valid), 32'd0);
      end
      bus.hsel = 0; bus.htrans = 0;

      for (int i = 0; i < 11; i++) begin
         run_xfer(vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata, vecs[i].prot,
                  vecs[i].delay, vecs[i].rdata);
         check_xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].exp_waits, vecs[i].exp_err,
                    vecs[i].exp_vcyc, vecs[i].exp_addr, vecs[i].exp_strb, vecs[i].exp_instr,
                    vecs[i].wdata, vecs[i].exp_hrdata);
      end

      // Back-to-back: read, then a write address presented in the read's completing cycle.
      pulses = 0; stage = 0; prev = 0; w_addr = 0; w_data = 0; w_strb = 0; r_addr = 0;
      bus.hsel = 1; bus.htrans = 2'b10; bus.haddr = 32'h0000_900C; bus.hwrite = 0;
      bus.hsize = 3'd2; bus.hprot = 4'b0001;
      step();
      bus.hsel = 0; bus.htrans = 0;
      for (int cyc = 0; cyc < 40 && stage != 3; cyc++) begin
         if (stage == 1) begin
            bus.hsel = 0; bus.htrans = 0; bus.hwdata = 32'h1122_3344; stage = 2;
         end
         if (bus.mem_valid) begin
            if (!prev) pulses++;
            bus.mem_ready = 1; bus.mem_rdata = 32'h0BAD_F00D;
            if (bus.mem_wstrb != 0) begin
               w_addr = bus.mem_addr; w_data = bus.mem_wdata; w_strb = bus.mem_wstrb;
            end else begin
               r_addr = bus.mem_addr;
            end
         end else begin
            bus.mem_ready = 0;
         end
         prev = bus.mem_valid;
         if (bus.hreadyout) begin
            if (stage == 0) begin
               chk("b2b read hrdata", bus.hrdata, 32'h0BAD_F00D);
               chk("b2b read hresp", 32'(bus.hresp), 32'd0);
               bus.hsel = 1; bus.htrans = 2'b10; bus.haddr = 32'h0000_9004;
               bus.hwrite = 1; bus.hsize = 3'd2;
               stage = 1;
            end else if (stage == 2) begin
               chk("b2b write hresp", 32'(bus.hresp), 32'd0);
               stage = 3;
            end
         end
         if (stage != 3) step();
      end
      chk("b2b completed", stage, 3);
      for (int i = 0; i < 4; i++) begin
         step();
         if (bus.mem_valid && !prev) pulses++;
         prev = bus.mem_valid;
      end
      chk("b2b pulses", pulses, 2);
      chk("b2b read addr", r_addr, 32'h0000_900C);
      chk("b2b write addr", w_addr, 32'h0000_9004);
      chk("b2b write data", w_data, 32'h1122_3344);
      chk("b2b write strb", 32'(w_strb), 32'hF);
      chk("b2b hrdata held", bus.hrdata, 32'h0BAD_F00D);

      // Reset while the native request is pending.
      bus.mem_ready = 0;
      bus.hsel = 1; bus.htrans = 2'b10; bus.haddr = 32'h0000_8000; bus.hwrite = 0;
      bus.hsize = 3'd2; bus.hprot = 4'b0001;
      step();
      bus.hsel = 0; bus.htrans = 0;
      step();
      chk("rst-mid pending", 32'(bus.mem_valid), 32'd1);
      resetn = 0;
      step();
      chk("rst-mid mem_valid", 32'(bus.mem_valid), 32'd0);
      chk("rst-mid hreadyout", 32'(bus.hreadyout), 32'd1);
      chk("rst-mid hresp", 32'(bus.hresp), 32'd0);
      chk("rst-mid hrdata", bus.hrdata, 32'd0);
      chk("rst-mid mem_addr", bus.mem_addr, 32'd0);
      resetn = 1;
      step();
      run_xfer(0, 3'd2, 32'h0000_8010, 32'h0, 4'b0001, 1, 32'h5A5A_A5A5);
      check_xfer("rst-mid follow", 0, 2, 0, 2, 32'h0000_8010, 4'b0000, 0, 32'h0, 32'h5A5A_A5A5);
      model_rdata = 32'h5A5A_A5A5;

      // Randomized transfers against the rule-level model.
      for (int i = 0; i < 40; i++) begin
         logic        wr, legal, tmo, err;
         logic [2:0]  size;
         logic [31:0] addr, wdata, rdata;
         logic [3:0]  prot, strb;
         int          delay, vcyc, waits, nbytes;
         wr    = 1'($urandom);
         size  = 3'($urandom_range(0, 3));
         addr  = $urandom;
         wdata = $urandom;
         rdata = $urandom;
         prot  = 4'($urandom);
         delay = $urandom_range(0, 5);
         nbytes = 1 << size;
         legal = (size <= 3'd2) && ((addr % nbytes) == 0);
         tmo   = legal && (delay >= TO);
         err   = !legal || tmo;
         vcyc  = !legal ? 0 : (tmo ? TO : delay + 1);
         waits = !legal ? 1 : (wr ? 1 : 0) + (tmo ? TO + 1 : delay + 1);
         strb  = wr ? 4'(((1 << nbytes) - 1) << (addr % 4)) : 4'b0000;
         if (legal && !wr && !tmo) model_rdata = rdata;
         run_xfer(wr, size, addr, wdata, prot, delay, rdata);
         check_xfer($sformatf("rnd%0d", i), wr, waits, err, vcyc, addr & ~32'd3, strb,
                    !prot[0], wdata, model_rdata);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
